// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM states and constants for the multiply/divide unit.
// Optional feature macro used by the MDU files: MDU_MADD_EN (multiply-accumulate ops).
`timescale 1ns/1ps
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MADD  = 4'd4,
      OP_MADDU = 4'd5,
      OP_MSUB  = 4'd6,
      OP_MSUBU = 4'd7,
      OP_MTHI  = 4'd8,
      OP_MTLO  = 4'd9
   } mdu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_ACC  = 3'd2,
      ST_DIV  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_e;

   localparam int          DIV_ITERS = 32;
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

   // Codes 10..15 are unused and must never be accepted.
   function automatic logic op_valid(input logic [3:0] op);
      return op <= OP_MTLO;
   endfunction

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_acc(input logic [3:0] op);
      return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic op_is_sub(input logic [3:0] op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   // Signed multiplies sign-extend their operands; the U variants zero-extend.
   function automatic logic op_is_signed(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// div_core: unsigned 32/32 radix-2 restoring divider, one quotient bit per step.
// quot/rem present the result of the step in progress so the controller can
// commit the final result on the same edge as the last step.
`timescale 1ns/1ps
module div_core
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        step,
   output logic [31:0] quot,
   output logic [31:0] rem,
   output logic        last
);

   logic [31:0] q_r;
   logic [31:0] r_r;
   logic [31:0] d_r;
   logic [5:0]  cnt_r;
   logic [32:0] r_sh;
   logic [32:0] r_sub;
   logic        ge;

   // Trial subtraction: partial remainder is always below 2*divisor, so bit 32
   // of the difference is the borrow.
   always_comb begin
      r_sh  = {r_r, q_r[31]};
      r_sub = r_sh - {1'b0, d_r};
      ge    = ~r_sub[32];
      quot  = {q_r[30:0], ge};
      rem   = ge ? r_sub[31:0] : r_sh[31:0];
      last  = step && (cnt_r == 6'(DIV_ITERS - 1));
   end

   // Iteration state: load restarts the division, step shifts in one quotient bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q_r   <= '0;
         r_r   <= '0;
         d_r   <= '0;
         cnt_r <= '0;
      end else if (load) begin
         q_r   <= dividend;
         r_r   <= '0;
         d_r   <= divisor;
         cnt_r <= '0;
      end else if (step) begin
         q_r   <= quot;
         r_r   <= rem;
         cnt_r <= cnt_r + 6'd1;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS multiply/divide unit controller owning HI/LO.
// Sequences mult/div/madd/msub/mthi/mtlo with a start/done handshake to EX.
// Optional macro MDU_MADD_EN enables the multiply-accumulate path (ACC state);
// without it MADD/MSUB ops complete immediately and leave HI/LO untouched.
`timescale 1ns/1ps
module mdu_ctrl
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e         state;
   logic [3:0]         op_p0;
   logic               neg_q_p0;
   logic               neg_r_p0;
   logic [31:0]        a_p0;
   logic [31:0]        b_p0;
   logic               accept;
   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] product;
   logic [31:0]        a_mag;
   logic [31:0]        b_mag;
   logic               div_load;
   logic               div_step;
   logic [31:0]        div_quot;
   logic [31:0]        div_rem;
   logic               div_last;

   // Acceptance, operand extension/magnitudes and handshake outputs.
   always_comb begin
      accept   = (state == ST_IDLE) && start && !cancel && op_valid(op);
      a_ext    = op_is_signed(op_p0) ? {{32{a_p0[31]}}, a_p0} : {32'b0, a_p0};
      b_ext    = op_is_signed(op_p0) ? {{32{b_p0[31]}}, b_p0} : {32'b0, b_p0};
      product  = a_ext * b_ext;
      a_mag    = ((op == OP_DIV) && src_a[31]) ? -src_a : src_a;
      b_mag    = ((op == OP_DIV) && src_b[31]) ? -src_b : src_b;
      div_load = accept && op_is_div(op) && (src_b != 32'd0);
      div_step = (state == ST_DIV) && !cancel;
      busy     = (state != ST_IDLE);
      done     = (state == ST_DONE);
   end

   div_core u_div_core (
      .clk      (clk),
      .resetn   (resetn),
      .load     (div_load),
      .dividend (a_mag),
      .divisor  (b_mag),
      .step     (div_step),
      .quot     (div_quot),
      .rem      (div_rem),
      .last     (div_last)
   );

   // Operand capture at acceptance (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0 <= src_a;
         b_p0 <= src_b;
      end
   end

`ifdef MDU_MADD_EN
   logic [63:0] prod_p1;
   logic [63:0] acc_sum;

   // Product held for the accumulate stage.
   always_ff @(posedge clk) begin
      if (state == ST_MUL) prod_p1 <= product;
   end

   // HI/LO plus or minus the held product, wrapping mod 2^64.
   always_comb begin
      acc_sum = op_is_sub(op_p0) ? ({hi, lo} - prod_p1) : ({hi, lo} + prod_p1);
   end
`endif

   // Control FSM and HI/LO commit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         op_p0    <= OP_MULT;
         neg_q_p0 <= 1'b0;
         neg_r_p0 <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_p0    <= op;
                  neg_q_p0 <= (op == OP_DIV) && (src_a[31] ^ src_b[31]);
                  neg_r_p0 <= (op == OP_DIV) && src_a[31];
                  case (op)
                     OP_MTHI: begin
                        hi    <= src_a;
                        state <= ST_DONE;
                     end
                     OP_MTLO: begin
                        lo    <= src_a;
                        state <= ST_DONE;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (src_b == 32'd0) begin
                           lo    <= DIV0_QUOT;
                           hi    <= src_a;
                           state <= ST_DONE;
                        end else begin
                           state <= ST_DIV;
                        end
                     end
                     OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`ifdef MDU_MADD_EN
                        state <= ST_MUL;
`else
                        state <= ST_DONE;
`endif
                     end
                     default: state <= ST_MUL;
                  endcase
               end
            end
            ST_MUL: begin
               if (cancel) begin
                  state <= ST_IDLE;
`ifdef MDU_MADD_EN
               end else if (op_is_acc(op_p0)) begin
                  state <= ST_ACC;
`endif
               end else begin
                  {hi, lo} <= product;
                  state    <= ST_DONE;
               end
            end
            ST_ACC: begin
`ifdef MDU_MADD_EN
               if (cancel) begin
                  state <= ST_IDLE;
               end else begin
                  {hi, lo} <= acc_sum;
                  state    <= ST_DONE;
               end
`else
               state <= ST_IDLE;
`endif
            end
            ST_DIV: begin
               if (cancel) begin
                  state <= ST_IDLE;
               end else if (div_last) begin
                  lo    <= neg_q_p0 ? -div_quot : div_quot;
                  hi    <= neg_r_p0 ? -div_rem  : div_rem;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
